slc3_isdu: RTL and testbench

- Instruction sequencing and decode unit for the SLC-3 CPU; sits directly upstream of the datapath.
- Moore FSM that walks fetch, decode and execute for each instruction.
- Drives every datapath load, gate and mux-select line, plus SRAM read/write strobes.
- Inputs are the IR opcode fields, BEN and front-panel Run/Continue.

---
 rtl/slc3_isdu.sv | 223 ++++++++++++++++++++++
 tb/tb_slc3_isdu.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/slc3_isdu.sv
// SLC-3 instruction sequencing and decode unit: a Moore FSM that drives the datapath controls.
// Optional macro ISDU_PAUSE_EN enables the PAUSE opcode (1101) with the Continue handshake.
`timescale 1ns / 1ps

module slc3_isdu #(
  parameter int unsigned MEM_WAIT = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       Run,
  input  logic       Continue,
  input  logic [3:0] Opcode,
  input  logic       IR_5,
  input  logic       IR_11,
  input  logic       BEN,
  output logic       LD_MAR,
  output logic       LD_MDR,
  output logic       LD_IR,
  output logic       LD_BEN,
  output logic       LD_CC,
  output logic       LD_REG,
  output logic       LD_PC,
  output logic       LD_LED,
  output logic       GatePC,
  output logic       GateMDR,
  output logic       GateALU,
  output logic       GateMARMUX,
  output logic [1:0] PCMUX,
  output logic       DRMUX,
  output logic       SR1MUX,
  output logic       SR2MUX,
  output logic       ADDR1MUX,
  output logic [1:0] ADDR2MUX,
  output logic [1:0] ALUK,
  output logic       MIO_EN,
  output logic       Mem_OE,
  output logic       Mem_WE
);

  typedef enum logic [4:0] {
    StHalted, StF1, StF2, StF3, StDecode,
    StAdd, StAnd, StNot, StBr, StBrT, StJmp, StJsr1, StJsr2,
    StLdr1, StLdr2, StLdr3, StStr1, StStr2, StStr3,
    StPause1, StPause2
  } state_e;

  localparam logic [2:0] MemWaitLast = 3'(MEM_WAIT);

  state_e     state_q, state_d;
  logic [2:0] wait_q, wait_d;
  logic       mem_done;

`ifndef ISDU_PAUSE_EN
  logic unused_continue;
  assign unused_continue = Continue;
`endif

  assign mem_done = (wait_q == MemWaitLast);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StHalted;
      wait_q  <= 3'd0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  // Counter is zero in every non-memory state, so each memory state is entered with it cleared.
  always_comb begin
    state_d = state_q;
    wait_d  = 3'd0;
    unique case (state_q)
      StHalted: if (Run) state_d = StF1;
      StF1:     state_d = StF2;
      StF2: begin
        if (mem_done) state_d = StF3;
        else          wait_d  = wait_q + 3'd1;
      end
      StF3:     state_d = StDecode;
      StDecode: begin
        state_d = StF1;
        unique case (Opcode)
          4'b0001: state_d = StAdd;
          4'b0101: state_d = StAnd;
          4'b1001: state_d = StNot;
          4'b0000: state_d = StBr;
          4'b1100: state_d = StJmp;
          4'b0100: state_d = IR_11 ? StJsr1 : StF1;
          4'b0110: state_d = StLdr1;
          4'b0111: state_d = StStr1;
`ifdef ISDU_PAUSE_EN
          4'b1101: state_d = StPause1;
`endif
          default: state_d = StF1;
        endcase
      end
      StAdd, StAnd, StNot, StBrT, StJmp, StJsr2, StLdr3: state_d = StF1;
      StBr:   state_d = BEN ? StBrT : StF1;
      StJsr1: state_d = StJsr2;
      StLdr1: state_d = StLdr2;
      StLdr2: begin
        if (mem_done) state_d = StLdr3;
        else          wait_d  = wait_q + 3'd1;
      end
      StStr1: state_d = StStr2;
      StStr2: state_d = StStr3;
      StStr3: begin
        if (mem_done) state_d = StF1;
        else          wait_d  = wait_q + 3'd1;
      end
`ifdef ISDU_PAUSE_EN
      StPause1: if (Continue)  state_d = StPause2;
      StPause2: if (!Continue) state_d = StF1;
`endif
      default: state_d = StHalted;
    endcase
  end

  always_comb begin
    LD_MAR     = 1'b0;
    LD_MDR     = 1'b0;
    LD_IR      = 1'b0;
    LD_BEN     = 1'b0;
    LD_CC      = 1'b0;
    LD_REG     = 1'b0;
    LD_PC      = 1'b0;
    LD_LED     = 1'b0;
    GatePC     = 1'b0;
    GateMDR    = 1'b0;
    GateALU    = 1'b0;
    GateMARMUX = 1'b0;
    PCMUX      = 2'b00;
    DRMUX      = 1'b0;
    SR1MUX     = 1'b0;
    SR2MUX     = 1'b0;
    ADDR1MUX   = 1'b0;
    ADDR2MUX   = 2'b00;
    ALUK       = 2'b00;
    MIO_EN     = 1'b0;
    Mem_OE     = 1'b0;
    Mem_WE     = 1'b0;
    unique case (state_q)
      StF1: begin
        GatePC = 1'b1;
        LD_MAR = 1'b1;
        LD_PC  = 1'b1;
      end
      // MDR captures only once the SRAM data has had MEM_WAIT extra cycles to settle.
      StF2, StLdr2: begin
        Mem_OE = 1'b1;
        MIO_EN = 1'b1;
        LD_MDR = mem_done;
      end
      StF3: begin
        GateMDR = 1'b1;
        LD_IR   = 1'b1;
      end
      StDecode: LD_BEN = 1'b1;
      StAdd, StAnd: begin
        SR1MUX  = 1'b1;
        SR2MUX  = IR_5;
        ALUK    = (state_q == StAnd) ? 2'b01 : 2'b00;
        GateALU = 1'b1;
        LD_REG  = 1'b1;
        LD_CC   = 1'b1;
      end
      StNot: begin
        SR1MUX  = 1'b1;
        ALUK    = 2'b10;
        GateALU = 1'b1;
        LD_REG  = 1'b1;
        LD_CC   = 1'b1;
      end
      StBrT: begin
        ADDR2MUX = 2'b10;
        PCMUX    = 2'b10;
        LD_PC    = 1'b1;
      end
      StJmp: begin
        SR1MUX   = 1'b1;
        ADDR1MUX = 1'b1;
        PCMUX    = 2'b10;
        LD_PC    = 1'b1;
      end
      StJsr1: begin
        GatePC = 1'b1;
        DRMUX  = 1'b1;
        LD_REG = 1'b1;
      end
      StJsr2: begin
        ADDR2MUX = 2'b11;
        PCMUX    = 2'b10;
        LD_PC    = 1'b1;
      end
      StLdr1, StStr1: begin
        SR1MUX     = 1'b1;
        ADDR1MUX   = 1'b1;
        ADDR2MUX   = 2'b01;
        GateMARMUX = 1'b1;
        LD_MAR     = 1'b1;
      end
      StLdr3: begin
        GateMDR = 1'b1;
        LD_REG  = 1'b1;
        LD_CC   = 1'b1;
      end
      // Store data comes from SR (IR[11:9]) passed straight through the ALU.
      StStr2: begin
        ALUK    = 2'b11;
        GateALU = 1'b1;
        LD_MDR  = 1'b1;
      end
      StStr3: Mem_WE = 1'b1;
`ifdef ISDU_PAUSE_EN
      StPause1: LD_LED = 1'b1;
`endif
      default: ;
    endcase
  end

endmodule

// File: tb/tb_slc3_isdu.sv
// Scoreboard bench for slc3_isdu: two instances (MEM_WAIT=2 and 0), per-cycle control vectors
// predicted from the instruction-level behaviour and checked by a negedge monitor.
`timescale 1ns / 1ps

module tb_slc3_isdu;

  typedef struct packed {
    logic       ld_mar, ld_mdr, ld_ir, ld_ben, ld_cc, ld_reg, ld_pc, ld_led;
    logic       gate_pc, gate_mdr, gate_alu, gate_marmux;
    logic [1:0] pcmux;
    logic       drmux, sr1mux, sr2mux, addr1mux;
    logic [1:0] addr2mux, aluk;
    logic       mio_en, mem_oe, mem_we;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_s [2];
  logic       run_s   [2];
  logic       cont_s  [2];
  logic [3:0] opc_s   [2];
  logic       ir5_s   [2];
  logic       ir11_s  [2];
  logic       ben_s   [2];
  logic       armed   [2] = '{1'b0, 1'b0};
  int         step    [2] = '{0, 0};

  vec_t q0[$];
  vec_t q1[$];
  int total = 0;
  int bad   = 0;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int unsigned MW = (g == 0) ? 2 : 0;
    logic LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED;
    logic GatePC, GateMDR, GateALU, GateMARMUX;
    logic [1:0] PCMUX, ADDR2MUX, ALUK;
    logic DRMUX, SR1MUX, SR2MUX, ADDR1MUX, MIO_EN, Mem_OE, Mem_WE;
    vec_t got_v;

    slc3_isdu #(.MEM_WAIT(MW)) u_dut (
      .clk(clk), .reset(reset_s[g]), .Run(run_s[g]), .Continue(cont_s[g]),
      .Opcode(opc_s[g]), .IR_5(ir5_s[g]), .IR_11(ir11_s[g]), .BEN(ben_s[g]),
      .LD_MAR(LD_MAR), .LD_MDR(LD_MDR), .LD_IR(LD_IR), .LD_BEN(LD_BEN), .LD_CC(LD_CC),
      .LD_REG(LD_REG), .LD_PC(LD_PC), .LD_LED(LD_LED), .GatePC(GatePC), .GateMDR(GateMDR),
      .GateALU(GateALU), .GateMARMUX(GateMARMUX), .PCMUX(PCMUX), .DRMUX(DRMUX),
      .SR1MUX(SR1MUX), .SR2MUX(SR2MUX), .ADDR1MUX(ADDR1MUX), .ADDR2MUX(ADDR2MUX),
      .ALUK(ALUK), .MIO_EN(MIO_EN), .Mem_OE(Mem_OE), .Mem_WE(Mem_WE)
    );

    assign got_v = {LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED,
                    GatePC, GateMDR, GateALU, GateMARMUX, PCMUX, DRMUX, SR1MUX, SR2MUX,
                    ADDR1MUX, ADDR2MUX, ALUK, MIO_EN, Mem_OE, Mem_WE};
  end

  function automatic int mw_of(input int d);
    return (d == 0) ? 2 : 0;
  endfunction

  task automatic push(input int d, input vec_t v, inout int n);
    if (d == 0) q0.push_back(v);
    else        q1.push_back(v);
    n++;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: one expected vector per cycle for each armed instance.
  task automatic check(input int d);
    vec_t act, exp_v;
    int   sz;
    act = (d == 0) ? g_dut[0].got_v : g_dut[1].got_v;
    sz  = (d == 0) ? q0.size() : q1.size();
    total++;
    step[d]++;
    if (sz == 0) begin
      bad++;
      $display("FAIL dut%0d step%0d underflow: got %h, no expectation queued", d, step[d], act);
    end else begin
      if (d == 0) exp_v = q0.pop_front();
      else        exp_v = q1.pop_front();
      if (act !== exp_v) begin
        bad++;
        $display("FAIL dut%0d step%0d outputs: got %h want %h", d, step[d], act, exp_v);
      end
    end
  endtask

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) if (armed[d]) check(d);
  end

  task automatic push_fetch(input int d, inout int n);
    vec_t v;
    v = '0; v.gate_pc = 1; v.ld_mar = 1; v.ld_pc = 1; push(d, v, n);
    for (int i = 0; i <= mw_of(d); i++) begin
      v = '0; v.mem_oe = 1; v.mio_en = 1; v.ld_mdr = (i == mw_of(d)); push(d, v, n);
    end
    v = '0; v.gate_mdr = 1; v.ld_ir = 1; push(d, v, n);
    v = '0; v.ld_ben = 1; push(d, v, n);
  endtask

  task automatic push_exec(input int d, input logic [3:0] op, input logic ir5, ir11, ben,
                           inout int n);
    vec_t v;
    case (op)
      4'b0001, 4'b0101: begin
        v = '0; v.sr1mux = 1; v.sr2mux = ir5; v.aluk = (op == 4'b0101) ? 2'b01 : 2'b00;
        v.gate_alu = 1; v.ld_reg = 1; v.ld_cc = 1; push(d, v, n);
      end
      4'b1001: begin
        v = '0; v.sr1mux = 1; v.aluk = 2'b10; v.gate_alu = 1; v.ld_reg = 1; v.ld_cc = 1;
        push(d, v, n);
      end
      4'b0000: begin
        v = '0; push(d, v, n);
        if (ben) begin
          v = '0; v.addr2mux = 2'b10; v.pcmux = 2'b10; v.ld_pc = 1; push(d, v, n);
        end
      end
      4'b1100: begin
        v = '0; v.sr1mux = 1; v.addr1mux = 1; v.pcmux = 2'b10; v.ld_pc = 1; push(d, v, n);
      end
      4'b0100: if (ir11) begin
        v = '0; v.gate_pc = 1; v.drmux = 1; v.ld_reg = 1; push(d, v, n);
        v = '0; v.addr2mux = 2'b11; v.pcmux = 2'b10; v.ld_pc = 1; push(d, v, n);
      end
      4'b0110, 4'b0111: begin
        v = '0; v.sr1mux = 1; v.addr1mux = 1; v.addr2mux = 2'b01; v.gate_marmux = 1;
        v.ld_mar = 1; push(d, v, n);
        if (op == 4'b0110) begin
          for (int i = 0; i <= mw_of(d); i++) begin
            v = '0; v.mem_oe = 1; v.mio_en = 1; v.ld_mdr = (i == mw_of(d)); push(d, v, n);
          end
          v = '0; v.gate_mdr = 1; v.ld_reg = 1; v.ld_cc = 1; push(d, v, n);
        end else begin
          v = '0; v.aluk = 2'b11; v.gate_alu = 1; v.ld_mdr = 1; push(d, v, n);
          for (int i = 0; i <= mw_of(d); i++) begin
            v = '0; v.mem_we = 1; push(d, v, n);
          end
        end
      end
      default: ;
    endcase
  endtask

  // Called at #1 after the edge that entered F1; returns at #1 after the next F1 entry.
  task automatic do_instr(input int d, input logic [3:0] op, input logic ir5, ir11, ben);
    int n;
    vec_t v;
    opc_s[d] = op; ir5_s[d] = ir5; ir11_s[d] = ir11; ben_s[d] = ben;
    n = 0;
    push_fetch(d, n);
`ifdef ISDU_PAUSE_EN
    if (op == 4'b1101) begin
      tick(n);
      n = 0;
      v = '0; v.ld_led = 1;
      repeat (20) push(d, v, n);
      tick(20);
      cont_s[d] = 1'b1;
      push(d, v, n);
      v = '0;
      repeat (5) push(d, v, n);
      tick(5);
      cont_s[d] = 1'b0;
      tick(1);
      return;
    end
`endif
    push_exec(d, op, ir5, ir11, ben, n);
    tick(n);
  endtask

  task automatic run_dut(input int d);
    int   n;
    int   k;
    vec_t v;
    logic [3:0] dir_op   [12] = '{4'b0001, 4'b0101, 4'b1001, 4'b0000, 4'b0000, 4'b0111,
                                  4'b0110, 4'b0100, 4'b0100, 4'b1100, 4'b1101, 4'b0011};
    logic       dir_ir5  [12] = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    logic       dir_ir11 [12] = '{0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1};
    logic       dir_ben  [12] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1};
    reset_s[d] = 1'b1; run_s[d] = 1'b0; cont_s[d] = 1'b0;
    opc_s[d] = 4'b0; ir5_s[d] = 1'b0; ir11_s[d] = 1'b0; ben_s[d] = 1'b0;
    tick(3);
    reset_s[d] = 1'b0;
    armed[d] = 1'b1;
    n = 0;
    v = '0;
    repeat (10) push(d, v, n);
    tick(10);
    push(d, v, n);
    run_s[d] = 1'b1;
    tick(1);
    run_s[d] = 1'b0;
    for (int i = 0; i < 12; i++) do_instr(d, dir_op[i], dir_ir5[i], dir_ir11[i], dir_ben[i]);
    for (int i = 0; i < 40; i++)
      do_instr(d, 4'($urandom_range(0, 15)), 1'($urandom), 1'($urandom), 1'($urandom));
    // Reset part-way through a fetch read must land in HALTED on the next edge.
    n = 0;
    v = '0; v.gate_pc = 1; v.ld_mar = 1; v.ld_pc = 1; push(d, v, n);
    tick(1);
    k = (mw_of(d) > 0) ? 1 : 0;
    for (int i = 0; i < k; i++) begin
      v = '0; v.mem_oe = 1; v.mio_en = 1; push(d, v, n);
      tick(1);
    end
    reset_s[d] = 1'b1;
    v = '0; v.mem_oe = 1; v.mio_en = 1; v.ld_mdr = (k == mw_of(d)); push(d, v, n);
    tick(1);
    reset_s[d] = 1'b0;
    v = '0;
    repeat (3) push(d, v, n);
    tick(3);
    armed[d] = 1'b0;
    reset_s[d] = 1'b1;
  endtask

  initial begin
    fork
      run_dut(0);
      run_dut(1);
    join
    for (int d = 0; d < 2; d++) begin
      int left;
      left = (d == 0) ? q0.size() : q1.size();
      total++;
      if (left != 0) begin
        bad++;
        $display("FAIL dut%0d drain: got %0d leftover entries want 0", d, left);
      end
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
